// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer
//
// Posted-write buffer between the CPU data-memory port and the dcache port.
// Stores are acknowledged one cycle after acceptance and drained to the dcache
// in program order. Loads go around pending stores unless they hit a buffered
// word. A load that hits a buffered word waits until that word has drained.
//
// Optional feature: define STORE_FWD_EN to let a load take its data from the
// buffer. This applies when the youngest buffered entry for the load's word
// has all four byte enables set.
//
// Ports
//   clk, reset_n          clock (rising edge) and asynchronous active-low reset
//   cpu_read, cpu_write   load / store request, held until cpu_resp
//   cpu_mbe, cpu_wdata    store byte enables and data
//   cpu_address           byte address; bits [1:0] are ignored
//   cpu_rdata, cpu_resp   load data and one-cycle completion pulse
//   dcache_read/write     registered dcache request, held until dcache_resp
//   dcache_mbe/address/wdata  registered request attributes
//   dcache_rdata, dcache_resp dcache load data and completion
//
// dcache port FSM
//   state    | meaning
//   ST_IDLE  | no dcache transaction; pick a load (priority) or a drain
//   ST_LOAD  | dcache_read outstanding for the pending CPU load
//   ST_DRAIN | dcache_write outstanding for the head entry
module dcache_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [3:0]  cpu_mbe,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [3:0]  dcache_mbe,
    output logic [31:0] dcache_address,
    output logic [31:0] dcache_wdata,
    input  logic [31:0] dcache_rdata,
    input  logic        dcache_resp
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_t;
    state_t state, state_nxt;

    logic [29:0]      buf_addr [DEPTH];
    logic [3:0]       buf_mbe  [DEPTH];
    logic [31:0]      buf_data [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic is_store, is_load, full, empty;
    logic push, pop, load_match, load_issue;
    logic addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_address[1:0];

    // The response cycle never evaluates the request inputs, so a request
    // the CPU still holds is not accepted twice. Read and write together
    // are treated as a store.
    assign is_store = cpu_write && !cpu_resp;
    assign is_load  = cpu_read && !cpu_write && !cpu_resp;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = (state == ST_DRAIN) && dcache_resp;
    // A full buffer still accepts a store in the cycle the head pops.
    assign push     = is_store && (!full || pop);

`ifdef STORE_FWD_EN
    logic [3:0]  hit_mbe;
    logic [31:0] hit_data;
    logic        fwd_hit;
`endif

    // Scan from oldest to youngest so the last hit is the youngest entry.
    always_comb begin
        load_match = 1'b0;
`ifdef STORE_FWD_EN
        hit_mbe  = '0;
        hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (buf_addr[head + PTR_W'(i)] == cpu_address[31:2])) begin
                load_match = 1'b1;
`ifdef STORE_FWD_EN
                hit_mbe  = buf_mbe[head + PTR_W'(i)];
                hit_data = buf_data[head + PTR_W'(i)];
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign fwd_hit = is_load && load_match && (hit_mbe == 4'hF);
`endif
    assign load_issue = is_load && !load_match;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_issue && !full) state_nxt = ST_LOAD;
                else if (!empty)         state_nxt = ST_DRAIN;
            end
            ST_LOAD:  if (dcache_resp) state_nxt = ST_IDLE;
            ST_DRAIN: if (dcache_resp) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            cpu_resp       <= 1'b0;
            cpu_rdata      <= '0;
            dcache_read    <= 1'b0;
            dcache_write   <= 1'b0;
            dcache_mbe     <= '0;
            dcache_address <= '0;
            dcache_wdata   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr[i] <= '0;
                buf_mbe[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            cpu_resp <= 1'b0;

            if (push) begin
                buf_addr[tail] <= cpu_address[31:2];
                buf_mbe[tail]  <= cpu_mbe;
                buf_data[tail] <= cpu_wdata;
                tail           <= tail + PTR_W'(1);
                cpu_resp       <= 1'b1;
            end
            if (pop) head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);

`ifdef STORE_FWD_EN
            if (fwd_hit) begin
                cpu_resp  <= 1'b1;
                cpu_rdata <= hit_data;
            end
`endif

            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_LOAD) begin
                        dcache_read    <= 1'b1;
                        dcache_address <= {cpu_address[31:2], 2'b00};
                        dcache_mbe     <= '0;
                        dcache_wdata   <= '0;
                    end else if (state_nxt == ST_DRAIN) begin
                        dcache_write   <= 1'b1;
                        dcache_address <= {buf_addr[head], 2'b00};
                        dcache_mbe     <= buf_mbe[head];
                        dcache_wdata   <= buf_data[head];
                    end
                end
                ST_LOAD: begin
                    if (dcache_resp) begin
                        dcache_read <= 1'b0;
                        cpu_rdata   <= dcache_rdata;
                        cpu_resp    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (dcache_resp) dcache_write <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_store_buffer.sv
module tb_dcache_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [3:0]  cpu_mbe = '0;
    logic [31:0] cpu_address = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;
    logic        dcache_read;
    logic        dcache_write;
    logic [3:0]  dcache_mbe;
    logic [31:0] dcache_address;
    logic [31:0] dcache_wdata;
    logic [31:0] dcache_rdata = '0;
    logic        dcache_resp = 1'b0;

    dcache_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_mbe(cpu_mbe),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_mbe(dcache_mbe), .dcache_address(dcache_address),
        .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata),
        .dcache_resp(dcache_resp)
    );

    always #5 clk = ~clk;

    // Reference model: the stores the buffer is holding, oldest first.
    typedef struct packed {
        logic [29:0] word;
        logic [3:0]  mbe;
        logic [31:0] data;
    } st_t;
    st_t sq[$];

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;

    // dcache responder state
    logic        dc_busy = 1'b0, dc_is_wr = 1'b0, dc_hold = 1'b0;
    int          dc_lat = 0;
    logic [31:0] dc_addr = '0, dc_wdata = '0;
    logic [3:0]  dc_mbe = '0;
    int          n_rd = 0, n_wr = 0, last_pop_cyc = -1;
    logic [31:0] last_rd_data = '0;
    logic        rd_force = 1'b0;
    logic [31:0] rd_force_val = '0;
    logic [29:0] load_word = '0;
    logic        load_active = 1'b0;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic release_hold();
        dc_hold = 1'b0;
        dc_lat  = 0;
    endtask

    // One clock: sample after the edge, retire/observe dcache traffic, drive resp.
    task automatic tick();
        bit ok;
        bit m;
        @(posedge clk);
        #1;
        cyc++;
        if (dcache_resp) begin
            dcache_resp = 1'b0;
            dc_busy = 1'b0;
            if (dc_is_wr) begin
                if (sq.size() > 0) void'(sq.pop_front());
                last_pop_cyc = cyc;
            end
        end
        if (!dc_busy) begin
            if (dcache_read || dcache_write) begin
                chk("dc_one_op", 32'(dcache_read && dcache_write), 0);
                dc_busy  = 1'b1;
                dc_is_wr = dcache_write;
                dc_addr  = dcache_address;
                dc_mbe   = dcache_mbe;
                dc_wdata = dcache_wdata;
                dc_lat   = int'($urandom_range(0, 3));
                if (dcache_write) begin
                    n_wr++;
                    chk("drain_nonempty", 32'(sq.size() != 0), 1);
                    if (sq.size() != 0) begin
                        chk("drain_addr", dcache_address, {sq[0].word, 2'b00});
                        chk("drain_mbe", 32'(dcache_mbe), 32'(sq[0].mbe));
                        chk("drain_data", dcache_wdata, sq[0].data);
                    end
                end else begin
                    n_rd++;
                    chk("load_active", 32'(load_active), 1);
                    chk("load_addr", dcache_address, {load_word, 2'b00});
                    m = 1'b0;
                    foreach (sq[i]) if (sq[i].word == dcache_address[31:2]) m = 1'b1;
                    chk("load_bypass_order", 32'(m), 0);
                end
            end
        end else begin
            ok = (dcache_read === ~dc_is_wr) && (dcache_write === dc_is_wr) &&
                 (dcache_address === dc_addr) &&
                 (!dc_is_wr || ((dcache_mbe === dc_mbe) && (dcache_wdata === dc_wdata)));
            chk("dc_stable", 32'(ok), 1);
        end
        dcache_rdata = $urandom;
        if (dc_busy && !dc_hold) begin
            if (dc_lat == 0) begin
                dcache_resp = 1'b1;
                if (!dc_is_wr) begin
                    if (rd_force) dcache_rdata = rd_force_val;
                    last_rd_data = dcache_rdata;
                end
            end else begin
                dc_lat--;
            end
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [3:0] mbe,
                            input logic [31:0] data, input int rel_after, output int lat);
        int skip;
        bit was_full;
        st_t e;
        skip = (cpu_resp === 1'b1) ? 1 : 0;
        was_full = (sq.size() >= DEPTH);
        cpu_read = 1'b0; cpu_write = 1'b1;
        cpu_address = addr; cpu_mbe = mbe; cpu_wdata = data;
        lat = 0;
        do begin
            tick();
            lat++;
            if (skip == 1 && lat == 1) chk("resp_pulse", 32'(cpu_resp), 0);
            if (lat == rel_after) release_hold();
        end while (cpu_resp !== 1'b1 && lat < 200);
        chk("store_resp", 32'(cpu_resp), 1);
        if (!was_full) chk("store_lat", lat, 1 + skip);
        e.word = addr[31:2]; e.mbe = mbe; e.data = data;
        sq.push_back(e);
        cpu_write = 1'b0;
        cpu_address = $urandom;
        cpu_wdata = $urandom;
    endtask

    task automatic do_load(input logic [31:0] addr, input int rel_after,
                           output int lat, output int used_dc);
        int skip, rd0;
        bit fwd_ok;
        logic [31:0] fwd_data;
        skip = (cpu_resp === 1'b1) ? 1 : 0;
        rd0 = n_rd;
        fwd_ok = 1'b0;
        fwd_data = '0;
        foreach (sq[i]) begin
            if (sq[i].word == addr[31:2]) begin
                fwd_ok = (sq[i].mbe == 4'hF);
                fwd_data = sq[i].data;
            end
        end
`ifndef STORE_FWD_EN
        fwd_ok = 1'b0;
`endif
        load_word = addr[31:2];
        load_active = 1'b1;
        cpu_write = 1'b0; cpu_read = 1'b1; cpu_address = addr;
        lat = 0;
        do begin
            tick();
            lat++;
            if (skip == 1 && lat == 1) chk("resp_pulse", 32'(cpu_resp), 0);
            if (lat == rel_after) release_hold();
        end while (cpu_resp !== 1'b1 && lat < 200);
        load_active = 1'b0;
        chk("load_resp", 32'(cpu_resp), 1);
        used_dc = n_rd - rd0;
        chk("load_reads_le1", 32'(used_dc <= 1), 1);
        if (used_dc != 0) begin
            chk("load_data", cpu_rdata, last_rd_data);
        end else begin
            chk("load_fwd_allowed", 32'(fwd_ok), 1);
            chk("load_fwd_data", cpu_rdata, fwd_data);
            chk("load_fwd_lat", lat, 1 + skip);
        end
        cpu_read = 1'b0;
        cpu_address = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sq.size() != 0 || dc_busy) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_idle_timeout", 32'(n < 200), 1);
    endtask

    initial begin
        int lat, used, w0;
        logic [31:0] a;
        logic [3:0]  m;

        // reset values
        #12;
        chk("rst_cpu_resp", 32'(cpu_resp), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dc_read", 32'(dcache_read), 0);
        chk("rst_dc_write", 32'(dcache_write), 0);
        chk("rst_dc_mbe", 32'(dcache_mbe), 0);
        chk("rst_dc_addr", dcache_address, 0);
        chk("rst_dc_wdata", dcache_wdata, 0);
        reset_n = 1'b1;
        tick();

        // single store and its drain
        w0 = n_wr;
        do_store(32'h100, 4'hF, 32'hDEADBEEF, -1, lat);
        chk("t1_store_lat", lat, 1);
        lat = 0;
        while (!dcache_write && lat < 50) begin tick(); lat++; end
        chk("t1_dc_write", 32'(dcache_write), 1);
        chk("t1_addr", dcache_address, 32'h100);
        chk("t1_data", dcache_wdata, 32'hDEADBEEF);
        chk("t1_mbe", 32'(dcache_mbe), 32'hF);
        wait_idle();
        chk("t1_one_write", n_wr - w0, 1);

        // DEPTH+1 stores with the dcache stalled
        dc_hold = 1'b1;
        w0 = n_wr;
        for (int i = 0; i < DEPTH; i++)
            do_store(32'h1000 + 32'(4 * i), 4'hF, $urandom, -1, lat);
        do_store(32'h1000 + 32'(4 * DEPTH), 4'hF, 32'h5555AAAA, 3, lat);
        chk("t2_stalled", 32'(lat > 2), 1);
        chk("t2_resp_at_pop", cyc, last_pop_cyc);
        wait_idle();
        chk("t2_writes", n_wr - w0, DEPTH + 1);

        // load bypasses a buffered store
        dc_hold = 1'b1;
        do_store(32'h180, 4'hF, $urandom, -1, lat);
        do_store(32'h200, 4'hF, 32'h0BADF00D, -1, lat);
        w0 = n_wr;
        rd_force = 1'b1;
        rd_force_val = 32'h12345678;
        do_load(32'h300, 2, lat, used);
        rd_force = 1'b0;
        chk("t3_used_dc", used, 1);
        chk("t3_load_first", n_wr - w0, 0);
        chk("t3_rdata", cpu_rdata, 32'h12345678);
        wait_idle();

        // full-word match: forward or stall
        dc_hold = 1'b1;
        do_store(32'h400, 4'hF, 32'hCAFEF00D, -1, lat);
        do_load(32'h402, 4, lat, used);
`ifdef STORE_FWD_EN
        chk("t4_fwd_lat", lat, 2);
        chk("t4_no_read", used, 0);
        chk("t4_data", cpu_rdata, 32'hCAFEF00D);
`else
        chk("t4_used_dc", used, 1);
        chk("t4_stalled", 32'(lat > 4), 1);
`endif
        release_hold();
        wait_idle();

        // partial-mbe match always stalls
        dc_hold = 1'b1;
        do_store(32'h500, 4'b0011, 32'h00001234, -1, lat);
        do_load(32'h500, 4, lat, used);
        chk("t5_used_dc", used, 1);
        chk("t5_stalled", 32'(lat > 4), 1);
        release_hold();
        wait_idle();

        // reset in the middle of a drain with three entries buffered
        dc_hold = 1'b1;
        for (int i = 0; i < 3; i++)
            do_store(32'h700 + 32'(4 * i), 4'hF, $urandom, -1, lat);
        chk("t6_in_drain", 32'(dcache_write), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_cpu_resp", 32'(cpu_resp), 0);
        chk("t6_cpu_rdata", cpu_rdata, 0);
        chk("t6_dc_read", 32'(dcache_read), 0);
        chk("t6_dc_write", 32'(dcache_write), 0);
        chk("t6_dc_mbe", 32'(dcache_mbe), 0);
        chk("t6_dc_addr", dcache_address, 0);
        chk("t6_dc_wdata", dcache_wdata, 0);
        sq.delete();
        dc_busy = 1'b0;
        dcache_resp = 1'b0;
        dc_hold = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        w0 = n_wr;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_no_drain", n_wr - w0, 0);
        do_store(32'h900, 4'hF, 32'h13579BDF, -1, lat);
        chk("t6_store_lat", lat, 1);
        wait_idle();
        chk("t6_one_write", n_wr - w0, 1);

        // randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            a = 32'h800 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 2) begin
                m = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15));
                do_store(a, m, $urandom, -1, lat);
            end else begin
                do_load(a, -1, lat, used);
            end
            if ($urandom_range(0, 7) == 0) tick();
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
